// File: rtl/imem_loader.sv
// Streams a length-prefixed, checksummed firmware image into imem
// one whole word per write, holding the CPU in reset until it verifies.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int BPW = WORD_W / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IW  = ADDR_W + 1;
  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              cpu_q, cpu_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       len_n;
  logic [WORD_W+7:0] asm_w;

  assign byte_ready_o = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer  = byte_valid_i && byte_ready_o;
  assign len_n = {len_q[15:8], byte_i};
  assign asm_w = {asm_q, byte_i};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    sum_d   = sum_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cpu_d   = cpu_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cpu_d   = 1'b0;
          sum_d   = '0;
          idx_d   = '0;
          bcnt_d  = '0;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_i;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_n;
          if ({16'd0, len_n} > CAP) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_n == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          asm_d = asm_w[WORD_W-1:0];
          sum_d = sum_q + byte_i;
          if (bcnt_q == BW'(BPW - 1)) begin
            bcnt_d  = '0;
            we_d    = 1'b1;
            wdata_d = asm_w[WORD_W-1:0];
            waddr_d = idx_q[ADDR_W-1:0];
            idx_d   = idx_q + IW'(1);
            if ((32'(idx_q) + 32'd1) == {16'd0, len_q})
              state_d = S_CSUM;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (byte_i == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            cpu_d   = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      sum_q   <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cpu_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      sum_q   <= sum_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cpu_q   <= cpu_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign we_o        = we_q;
  assign waddr_o     = waddr_q;
  assign wdata_o     = wdata_q;
  assign cpu_rst_n_o = cpu_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: image-level model of expected writes and
// final status, checked every cycle against the DUT write port.
module tb_imem_loader;
  localparam int AW  = 3;
  localparam int WW  = 16;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [7:0]    byte_i = 8'h00;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic          we_o;
  logic [AW-1:0] waddr_o;
  logic [WW-1:0] wdata_o;
  logic          cpu_rst_n_o;
  logic          done_o;
  logic          err_o;

  imem_loader #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .we_o(we_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o),
    .cpu_rst_n_o(cpu_rst_n_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;
  logic [31:0] expq[$];
  logic [31:0] wlog[$];
  logic [7:0]  img[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Every write the DUT issues must be the next one the image predicts.
  always @(negedge clk) begin
    if (we_o) begin
      logic [31:0] w;
      w = (32'(waddr_o) << 16) | 32'(wdata_o);
      wlog.push_back(w);
      if (expq.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL spurious_write: got %h want none", w);
      end else begin
        chk("write", w, expq.pop_front());
      end
    end
  end

  function automatic logic [7:0] psum(int first, int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) s = s + img[first + i];
    return s;
  endfunction

  function automatic int img_len();
    return (int'(img[0]) << 8) | int'(img[1]);
  endfunction

  task automatic send_byte(logic [7:0] b, int gap, bit exp_we);
    int n;
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    byte_i = b;
    byte_valid_i = 1'b1;
    n = 0;
    while (!byte_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready_o) begin
      nchk++;
      nfail++;
      $display("FAIL ready_timeout: got 0 want 1");
      byte_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
    chk("we_latency", 32'(we_o), 32'(exp_we));
    @(negedge clk);
  endtask

  task automatic run_load(int nsend, int maxgap, bit start_mid);
    int n;
    bit wr;
    n = img_len();
    expq.delete();
    if (n <= CAP)
      for (int i = 0; i < n; i++)
        if (3 + 2 * i < nsend)
          expq.push_back((32'(i) << 16) |
                         (32'(img[2 + 2 * i]) << 8) |
                         32'(img[3 + 2 * i]));
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_status", {29'd0, cpu_rst_n_o, done_o, err_o}, 32'd0);
    for (int k = 0; k < nsend; k++) begin
      if (start_mid && k == 4) start_i = 1'b1;
      wr = (n <= CAP) && (k >= 2) && (k < 2 + 2 * n) && ((k % 2) == 1);
      send_byte(img[k], int'($urandom_range(0, maxgap)), wr);
      start_i = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("pending_writes", 32'(expq.size()), 32'd0);
  endtask

  task automatic check_end();
    int n;
    bit ok;
    n = img_len();
    ok = (n <= CAP) && (img.size() == 3 + 2 * n) &&
         (img[img.size() - 1] == psum(2, 2 * n));
    chk("done", 32'(done_o), 32'(ok));
    chk("err", 32'(err_o), 32'(!ok));
    chk("cpu_rst_n", 32'(cpu_rst_n_o), 32'(ok));
    chk("ready_idle", 32'(byte_ready_o), 32'd0);
  endtask

  task automatic check_reset_outs(string nm);
    chk(nm, {8'd0, we_o, waddr_o, wdata_o, cpu_rst_n_o,
             done_o, err_o, byte_ready_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    byte_valid_i = 1'b1;
    byte_i = 8'h5A;
    start_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_outs("reset_outs");
    end
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("idle_outs");

    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    chk("model_sum", 32'(psum(2, 4)), 32'h0000_00BE);
    wlog.delete();
    run_load(7, 0, 1'b0);
    check_end();
    chk("lit_w0", wlog[0], 32'h0000_1234);
    chk("lit_w1", wlog[1], 32'h0001_ABCD);
    chk("lit_done", 32'(done_o), 32'd1);

    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h6F};
    wlog.delete();
    run_load(7, 0, 1'b0);
    check_end();
    chk("lit_bad_writes", 32'(wlog.size()), 32'd2);
    chk("lit_bad_err", {30'd0, err_o, cpu_rst_n_o}, 32'd2);

    img = '{8'h00, 8'h00, 8'h00};
    wlog.delete();
    run_load(3, 0, 1'b0);
    check_end();
    chk("lit_n0", {29'd0, done_o, err_o, cpu_rst_n_o}, 32'd5);

    img = '{8'h00, 8'h09};
    run_load(2, 0, 1'b0);
    check_end();
    chk("lit_ovf", 32'(err_o), 32'd1);

    img = '{8'h00, 8'h08};
    for (int i = 0; i < 16; i++) img.push_back(8'(i * 37 + 5));
    img.push_back(psum(2, 16));
    run_load(19, 1, 1'b0);
    check_end();

    img = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    wlog.delete();
    run_load(7, 5, 1'b0);
    check_end();
    chk("gap_w0", wlog[0], 32'h0000_1234);
    chk("gap_w1", wlog[1], 32'h0001_ABCD);

    wlog.delete();
    run_load(5, 0, 1'b0);
    chk("abort_writes", 32'(wlog.size()), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outs("abort_outs");
    rst_n = 1'b1;
    @(negedge clk);
    wlog.delete();
    run_load(7, 2, 1'b1);
    check_end();
    chk("reload_w0", wlog[0], 32'h0000_1234);
    chk("reload_w1", wlog[1], 32'h0001_ABCD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end
endmodule
